cv32e40p_mac_seq_ctrl: RTL and testbench
========================================

Name: cv32e40p_mac_seq_ctrl

Overview:
Sequencer for the Q16.16 cumulative multiply-accumulate unit. It computes one dot product per start command.
- Fetches operand pairs A[k] and B[k] from memory over a single-outstanding req/gnt/rvalid port.
- Clears the MAC, pulses its enable once per pair, then adds a bias and optionally applies ReLU.
- Presents the final neuron/convolution output with a done pulse.
- Sits between the core-side config registers and the MAC datapath in the CNN accelerator path.

Parameters:
ADDR_W, 32, memory address width
LEN_W, 16, width of element-count field

Ports:
clk_i  input  1  clock
rst_n_global_i  input  1  reset, asynchronous, active-low
start_i  input  1  launch a dot product; sampled only in IDLE
abort_i  input  1  cancel the current operation
a_base_i  input  ADDR_W  byte address of A[0]
b_base_i  input  ADDR_W  byte address of B[0]
a_stride_i  input  ADDR_W  byte stride between A elements
b_stride_i  input  ADDR_W  byte stride between B elements
len_i  input  LEN_W  number of pairs N
bias_i  input  32  Q16.16 bias
relu_en_i  input  1  clamp negative result to 0
data_req_o  output  1  memory read request
data_addr_o  output  ADDR_W  read address
data_gnt_i  input  1  request accepted
data_rvalid_i  input  1  read data valid
data_rdata_i  input  32  read data
mac_clr_o  output  1  to MAC forced reset (active-high)
mac_en_o  output  1  to MAC enable
mac_a_o  output  32  MAC operand A
mac_b_o  output  32  MAC operand B
mac_result_i  input  32  MAC registered accumulator
busy_o  output  1  high in any state except IDLE
done_o  output  1  one-cycle pulse, result_o valid
result_o  output  32  final Q16.16 result

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0: data_req_o, data_addr_o, mac_clr_o, mac_en_o, mac_a_o, mac_b_o, busy_o, done_o, result_o.
  - Element counter k = 0.
- States: IDLE, CLEAR, REQ_A, WAIT_A, REQ_B, WAIT_B, ACC, DRAIN.
- IDLE:
  - On start_i, latch all config inputs and set k = 0, then go to CLEAR.
  - start_i in any other state is ignored.
- CLEAR (1 cycle):
  - mac_clr_o = 1.
  - Next state: REQ_A if N > 0, otherwise DRAIN.
- REQ_A:
  - data_req_o = 1 and data_addr_o = a_base + k*a_stride, held stable until data_gnt_i.
  - On gnt, go to WAIT_A.
- WAIT_A:
  - data_req_o = 0.
  - On data_rvalid_i, capture data_rdata_i into the A operand register and go to REQ_B.
  - rvalid arrives at least 1 cycle after gnt.
- REQ_B and WAIT_B: same as REQ_A/WAIT_A, using b_base + k*b_stride and the B operand register. After capture, go to ACC.
- ACC (1 cycle):
  - mac_en_o = 1; mac_a_o and mac_b_o are driven from the operand registers.
  - k increments.
  - Next state: DRAIN if k+1 == N, otherwise REQ_A.
- DRAIN (1 cycle):
  - mac_result_i already holds the final accumulation.
  - Compute s = mac_result_i + bias, 32-bit two's-complement wraparound.
  - If relu_en and s[31] = 1, then s = 0.
  - Register s into result_o and return to IDLE.
  - done_o is a registered pulse that is high in the cycle result_o updates.
  - result_o holds its value until the next DRAIN.
- Address arithmetic is modulo 2^ADDR_W. The product k*stride is implemented as an incrementing pointer per operand (add stride after each grant), not a multiplier.
- mac_en_o and mac_clr_o are never asserted together; each is high for exactly one cycle per event.
- abort_i:
  - In CLEAR, REQ_A, REQ_B or ACC: go to IDLE next cycle with no done_o. A request not yet granted is dropped.
  - In WAIT_A or WAIT_B: set an abort flag, consume the pending rvalid, then go to IDLE. Outstanding data is never orphaned.
  - Ignored in IDLE and DRAIN.
  - result_o is left unchanged on abort.
- Asynchronous reset mid-operation returns to reset values immediately. The bus is assumed reset by the same signal.
- Overflow of the accumulation is the MAC's concern; it wraps and is not detected here.

Test Plan:
- N=2, A=[0x00010000, 0x00020000], B=[0x00030000, 0x00008000], bias=0x00008000, gnt and rvalid immediate:
  - Expect 2 mac_en_o pulses and 1 mac_clr_o pulse.
  - Expect result_o=0x00048000 with done_o high for 1 cycle.
- Same operands, A[0]=0xFFFF0000 (-1.0), bias=0, relu_en=0:
  - Expect result_o = -3.0 + 1.0 = 0xFFFE0000.
  - Repeat with relu_en=1: expect 0x00000000.
- N=0, bias=0x12345678 -> no data_req_o; result_o=0x12345678 with done_o 3 cycles after start (IDLE→CLEAR→DRAIN).
- gnt delayed 3 cycles, rvalid 2 cycles after gnt, strides 4 and 8:
  - data_addr_o is stable while req is high.
  - Addresses seen: a_base, b_base, a_base+4, b_base+8.
  - Result matches the first scenario.
- abort_i asserted in WAIT_B with rvalid arriving 2 cycles later:
  - No further req and no done_o.
  - busy_o falls the cycle after rvalid.
  - A subsequent start completes correctly.
- start_i pulsed while busy, then rst_n_global_i asserted mid-REQ_A:
  - The second start has no effect.
  - On reset, all outputs go to 0 immediately.

Source files
------------

// File: rtl/cv32e40p_mac_seq_ctrl.sv
// Dot-product sequencer for the Q16.16 MAC: fetches A[k]/B[k] pairs over a
// single-outstanding req/gnt/rvalid port, steps the MAC, then applies bias and optional ReLU.
module cv32e40p_mac_seq_ctrl #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_global_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] a_base_i,
    input  logic [ADDR_W-1:0] b_base_i,
    input  logic [ADDR_W-1:0] a_stride_i,
    input  logic [ADDR_W-1:0] b_stride_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [31:0]       bias_i,
    input  logic              relu_en_i,
    output logic              data_req_o,
    output logic [ADDR_W-1:0] data_addr_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i,
    output logic              mac_clr_o,
    output logic              mac_en_o,
    output logic [31:0]       mac_a_o,
    output logic [31:0]       mac_b_o,
    input  logic [31:0]       mac_result_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       result_o
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, REQ_A, WAIT_A, REQ_B, WAIT_B, ACC, DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] a_ptr_q, b_ptr_q, a_stride_q, b_stride_q;
    logic [LEN_W-1:0]  len_q, k_q;
    logic [31:0]       bias_q, op_a_q, op_b_q, result_q, sum, drain_val;
    logic              relu_q, abort_q, done_q;
    logic              aborting;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_n_global_i) begin
        if (!rst_n_global_i) state_q <= IDLE;
        else                 state_q <= state_d;
    end

    // A pending read must still be consumed after an abort, so the flag is
    // combined with the live request while waiting for rvalid.
    assign aborting = abort_i || abort_q;

    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        data_req_o  = 1'b0;
        data_addr_o = '0;
        mac_clr_o   = 1'b0;
        mac_en_o    = 1'b0;
        unique case (state_q)
            IDLE:   if (start_i) state_d = CLEAR;
            CLEAR: begin
                mac_clr_o = 1'b1;
                if (abort_i)            state_d = IDLE;
                else if (len_q != '0)   state_d = REQ_A;
                else                    state_d = DRAIN;
            end
            REQ_A: begin
                data_req_o  = 1'b1;
                data_addr_o = a_ptr_q;
                if (data_gnt_i)   state_d = WAIT_A;
                else if (abort_i) state_d = IDLE;
            end
            WAIT_A: if (data_rvalid_i) state_d = aborting ? IDLE : REQ_B;
            REQ_B: begin
                data_req_o  = 1'b1;
                data_addr_o = b_ptr_q;
                if (data_gnt_i)   state_d = WAIT_B;
                else if (abort_i) state_d = IDLE;
            end
            WAIT_B: if (data_rvalid_i) state_d = aborting ? IDLE : ACC;
            ACC: begin
                mac_en_o = 1'b1;
                if (abort_i)                 state_d = IDLE;
                else if (k_q + 1'b1 == len_q) state_d = DRAIN;
                else                         state_d = REQ_A;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sum       = mac_result_i + bias_q;
    assign drain_val = (relu_q && sum[31]) ? 32'h0 : sum;

    always_ff @(posedge clk_i or negedge rst_n_global_i) begin
        if (!rst_n_global_i) begin
            a_ptr_q    <= '0;
            b_ptr_q    <= '0;
            a_stride_q <= '0;
            b_stride_q <= '0;
            len_q      <= '0;
            k_q        <= '0;
            bias_q     <= '0;
            relu_q     <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            abort_q    <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == DRAIN);
            if (state_q == IDLE) begin
                abort_q <= 1'b0;
            end else if (abort_i && (state_q == WAIT_A || state_q == WAIT_B ||
                         ((state_q == REQ_A || state_q == REQ_B) && data_gnt_i))) begin
                // A grant in the abort cycle still leaves data in flight.
                abort_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: if (start_i) begin
                    a_ptr_q    <= a_base_i;
                    b_ptr_q    <= b_base_i;
                    a_stride_q <= a_stride_i;
                    b_stride_q <= b_stride_i;
                    len_q      <= len_i;
                    bias_q     <= bias_i;
                    relu_q     <= relu_en_i;
                    k_q        <= '0;
                end
                REQ_A:  if (data_gnt_i)    a_ptr_q <= a_ptr_q + a_stride_q;
                REQ_B:  if (data_gnt_i)    b_ptr_q <= b_ptr_q + b_stride_q;
                WAIT_A: if (data_rvalid_i) op_a_q  <= data_rdata_i;
                WAIT_B: if (data_rvalid_i) op_b_q  <= data_rdata_i;
                ACC:    k_q      <= k_q + 1'b1;
                DRAIN:  result_q <= drain_val;
                default: ;
            endcase
        end
    end

    assign mac_a_o  = op_a_q;
    assign mac_b_o  = op_b_q;
    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_cv32e40p_mac_seq_ctrl.sv
// Bench for cv32e40p_mac_seq_ctrl: memory responder with programmable latencies,
// a Q16.16 MAC model, and a dot-product reference computed from the operand lists.
module tb_cv32e40p_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [31:0] a_base, b_base, a_stride, b_stride, bias;
    logic [15:0] len;
    logic        relu;
    logic        data_req_o, data_gnt, data_rvalid;
    logic [31:0] data_addr_o, data_rdata;
    logic        mac_clr_o, mac_en_o, busy_o, done_o;
    logic [31:0] mac_a_o, mac_b_o, mac_acc, result_o;

    int n_cmp = 0;
    int n_fail = 0;
    int en_cnt, clr_cnt, done_cnt;
    int gnt_delay, rv_delay;
    logic [31:0] addr_log[$];
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    cv32e40p_mac_seq_ctrl #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk_i(clk), .rst_n_global_i(rst_n),
        .start_i(start), .abort_i(abort),
        .a_base_i(a_base), .b_base_i(b_base),
        .a_stride_i(a_stride), .b_stride_i(b_stride),
        .len_i(len), .bias_i(bias), .relu_en_i(relu),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o),
        .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
        .mac_clr_o(mac_clr_o), .mac_en_o(mac_en_o),
        .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_result_i(mac_acc),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] q_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[47:16];
    endfunction

    // Registered Q16.16 accumulator standing in for the MAC datapath.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        mac_acc <= 32'h0;
        else if (mac_clr_o) mac_acc <= 32'h0;
        else if (mac_en_o)  mac_acc <= mac_acc + q_mul(mac_a_o, mac_b_o);
    end

    function automatic logic [31:0] ref_dot(input int n, input logic [31:0] b, input logic r);
        longint acc = 0;
        longint p;
        logic [31:0] s;
        for (int i = 0; i < n; i++) begin
            p = longint'($signed(a_q[i])) * longint'($signed(b_q[i]));
            acc += p >>> 16;
        end
        s = acc[31:0] + b;
        if (r && s[31]) s = 32'h0;
        return s;
    endfunction

    // Memory responder: grant after gnt_delay waiting cycles, rvalid rv_delay cycles later.
    initial begin : responder
        int req_wait;
        int rv_cnt;
        logic [31:0] held_addr, pend_addr;
        data_gnt = 0; data_rvalid = 0; data_rdata = 0;
        req_wait = 0; rv_cnt = 0; held_addr = 0; pend_addr = 0;
        forever begin
            @(negedge clk);
            data_gnt = 0;
            data_rvalid = 0;
            if (!rst_n) begin
                req_wait = 0;
                rv_cnt = 0;
            end else begin
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        data_rvalid = 1;
                        data_rdata = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
                    end
                end
                if (data_req_o) begin
                    if (req_wait == 0) held_addr = data_addr_o;
                    else check("addr_stable", data_addr_o, held_addr);
                    if (req_wait >= gnt_delay) begin
                        data_gnt = 1;
                        addr_log.push_back(data_addr_o);
                        pend_addr = data_addr_o;
                        rv_cnt = rv_delay;
                        req_wait = 0;
                    end else begin
                        req_wait++;
                    end
                end else begin
                    req_wait = 0;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mac_en_o)  en_cnt++;
            if (mac_clr_o) clr_cnt++;
            if (done_o)    done_cnt++;
            if (mac_en_o || mac_clr_o) check("en_clr_exclusive", 32'(mac_en_o & mac_clr_o), 32'h0);
        end
    end

    task automatic load_mem(input int n, input logic [31:0] ab, bb, as, bs);
        for (int i = 0; i < n; i++) begin
            mem[ab + as * 32'(i)] = a_q[i];
            mem[bb + bs * 32'(i)] = b_q[i];
        end
    endtask

    task automatic launch(input int n, input logic [31:0] ab, bb, as, bs, bi, input logic r);
        @(negedge clk);
        en_cnt = 0; clr_cnt = 0; done_cnt = 0;
        addr_log.delete();
        a_base = ab; b_base = bb; a_stride = as; b_stride = bs;
        len = 16'(n); bias = bi; relu = r; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run_op(input string tag, input int n, input logic [31:0] ab, bb, as, bs, bi,
                          input logic r, input int lat_exp, input int restart_at);
        logic [31:0] exp_r;
        int lat;
        load_mem(n, ab, bb, as, bs);
        exp_r = ref_dot(n, bi, r);
        launch(n, ab, bb, as, bs, bi, r);
        lat = 1;
        while (!done_o && lat < 2000) begin
            @(negedge clk);
            lat++;
            start = (lat == restart_at);
        end
        start = 0;
        check({tag, "_done_seen"}, 32'(done_o), 32'h1);
        if (lat_exp > 0) check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_result"}, result_o, exp_r);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_o), 32'h0);
        check({tag, "_result_hold"}, result_o, exp_r);
        repeat (3) @(negedge clk);
        check({tag, "_idle"}, 32'(busy_o), 32'h0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'h1);
        check({tag, "_clr_cnt"}, 32'(clr_cnt), 32'h1);
        check({tag, "_en_cnt"}, 32'(en_cnt), 32'(n));
        check({tag, "_req_cnt"}, 32'(addr_log.size()), 32'(2 * n));
        for (int i = 0; i < n && 2 * i + 1 < addr_log.size(); i++) begin
            check({tag, "_addr_a"}, addr_log[2 * i], ab + as * 32'(i));
            check({tag, "_addr_b"}, addr_log[2 * i + 1], bb + bs * 32'(i));
        end
    endtask

    initial begin : stimulus
        logic [31:0] saved;
        bit seen;
        int rn;
        rst_n = 0; start = 0; abort = 0;
        a_base = 0; b_base = 0; a_stride = 0; b_stride = 0; len = 0; bias = 0; relu = 0;
        gnt_delay = 0; rv_delay = 1;
        en_cnt = 0; clr_cnt = 0; done_cnt = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_req", 32'(data_req_o), 32'h0);
        check("rst_result", result_o, 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        rst_n = 1;

        a_q = '{32'h0001_0000, 32'h0002_0000};
        b_q = '{32'h0003_0000, 32'h0000_8000};
        run_op("basic", 2, 32'h1000, 32'h8000, 4, 4, 32'h0000_8000, 0, 0, 0);
        check("basic_const", result_o, 32'h0004_8000);

        a_q[0] = 32'hFFFF_0000;
        run_op("neg", 2, 32'h1000, 32'h8000, 4, 4, 32'h0, 0, 0, 0);
        check("neg_const", result_o, 32'hFFFE_0000);
        run_op("relu", 2, 32'h1000, 32'h8000, 4, 4, 32'h0, 1, 0, 0);
        check("relu_const", result_o, 32'h0);

        run_op("n0", 0, 32'h1000, 32'h8000, 4, 4, 32'h1234_5678, 0, 3, 0);

        a_q = '{32'h0001_0000, 32'h0002_0000};
        gnt_delay = 3; rv_delay = 2;
        run_op("slow", 2, 32'h100, 32'h200, 4, 8, 32'h0000_8000, 0, 0, 0);
        check("slow_const", result_o, 32'h0004_8000);

        // Abort while B[0] is outstanding.
        gnt_delay = 0; rv_delay = 3;
        saved = result_o;
        load_mem(2, 32'h1000, 32'h8000, 4, 4);
        launch(2, 32'h1000, 32'h8000, 4, 4, 32'h0, 0);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            seen = (addr_log.size() == 2);
        end
        check("abort_reached_wait_b", 32'(seen), 32'h1);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        check("abort_busy_wait", 32'(busy_o), 32'h1);
        @(posedge clk); #1;
        check("abort_busy_rvalid", 32'(busy_o), 32'h1);
        @(posedge clk); #1;
        check("abort_busy_fall", 32'(busy_o), 32'h0);
        repeat (5) @(negedge clk);
        check("abort_no_req", 32'(addr_log.size()), 32'h2);
        check("abort_no_done", 32'(done_cnt), 32'h0);
        check("abort_no_en", 32'(en_cnt), 32'h0);
        check("abort_result_kept", result_o, saved);
        rv_delay = 1;
        run_op("post_abort", 2, 32'h1000, 32'h8000, 4, 4, 32'h0, 0, 0, 0);

        // Start pulsed while busy must not relaunch.
        a_q = '{32'h0003_0000};
        b_q = '{32'hFFFE_8000};
        gnt_delay = 2;
        run_op("restart", 1, 32'h2000, 32'h9000, 4, 4, 32'h0001_0000, 0, 0, 3);

        for (int t = 0; t < 6; t++) begin
            rn = int'($urandom_range(1, 5));
            a_q.delete();
            b_q.delete();
            for (int i = 0; i < rn; i++) begin
                a_q.push_back($urandom);
                b_q.push_back($urandom);
            end
            gnt_delay = int'($urandom_range(0, 3));
            rv_delay = int'($urandom_range(1, 3));
            run_op("rand", rn, 32'h1000 + 32'($urandom_range(0, 15)) * 4,
                   32'h8000 + 32'($urandom_range(0, 15)) * 4,
                   32'($urandom_range(1, 16)) * 4, 32'($urandom_range(1, 16)) * 4,
                   $urandom, 1'($urandom_range(0, 1)), 0, 0);
        end

        // Asynchronous reset while a request is waiting for grant.
        gnt_delay = 20; rv_delay = 1;
        saved = result_o;
        launch(2, 32'h1000, 32'h8000, 4, 4, 32'h0, 0);
        @(negedge clk);
        check("rstmid_in_req", 32'(data_req_o), 32'h1);
        #1 rst_n = 0;
        #1;
        check("rstmid_req", 32'(data_req_o), 32'h0);
        check("rstmid_addr", data_addr_o, 32'h0);
        check("rstmid_busy", 32'(busy_o), 32'h0);
        check("rstmid_clr_en", 32'({mac_clr_o, mac_en_o}), 32'h0);
        check("rstmid_ops", mac_a_o | mac_b_o, 32'h0);
        check("rstmid_done", 32'(done_o), 32'h0);
        check("rstmid_result", result_o, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        gnt_delay = 0;
        a_q = '{32'h0001_0000, 32'h0002_0000};
        b_q = '{32'h0003_0000, 32'h0000_8000};
        run_op("post_reset", 2, 32'h1000, 32'h8000, 4, 4, 32'h0000_8000, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
